i2d_pipe_ctl: RTL
=================

// Module: i2d_pipe_ctl
// PURPOSE
// Pipeline sequencing controller for the i2d core. Watches the decode stage (operand regs, swi,
// id_err, branch) and EX/MEM writeback, and drives stall/flush/disable for IF, ID and EX.
// Owns load-use interlock, multi-cycle MUL/DIV hold, branch-taken flush and the swi/error
// exception sequence that redirects the PC to a vector.
// PARAMETERS
// MC_LAT    4   cycles a MUL/MULU/DIV/DIVU occupies EX (2..15)
// FLUSH_CYC 2   bubbles inserted after a taken branch or exception redirect (1..3)
// RF_AW     6   register-file address width
// PORTS
// clk          in   1      core clock, all state on posedge
// rst          in   1      asynchronous active-low reset
// id_valid     in   1      ID holds a real instruction
// id_ra        in   RF_AW  ID source A
// id_rb        in   RF_AW  ID source B
// id_rf_r      in   1      ID instruction reads id_ra/id_rb
// id_swi       in   1      ID instruction is SWI
// id_err       in   1      ID decode error (illegal opcode)
// id_pc        in   32     PC of ID instruction
// ex_load      in   1      EX instruction is a load
// ex_rd        in   RF_AW  EX destination
// ex_mc_start  in   1      EX just accepted a multi-cycle op (1-cycle pulse)
// br_taken     in   1      branch/CALL resolved taken in EX
// if_stall     out  1      hold PC and IF/ID register
// id_dis       out  1      decode disable: ID register loads bubble
// ex_bubble    out  1      EX loads NOP this cycle
// pc_sel       out  2      0 seq, 1 branch target, 2 exception vector
// exc_cause    out  2      0 none, 1 swi, 2 id_err (sticky until next exception)
// exc_pc       out  32     PC of excepting instruction
// BEHAVIOUR
// - Reset (rst==0, async): state=RUN, counters 0, exc_cause=0, exc_pc=0; all combinational
//   outputs evaluate to 0 in RUN with no hazard.
// - FSM: RUN, MCWAIT, FLUSH, EXC. Outputs combinational from state+inputs unless noted.
// - RUN priority (highest first): exception, branch, mc_start, load-use.
//   * id_valid&(id_swi|id_err): next EXC; latch exc_pc=id_pc, exc_cause=swi?1:2 (swi wins if
//     both); id_dis=1, ex_bubble=1 this cycle.
//   * br_taken: pc_sel=1 this cycle; id_dis=1, ex_bubble=1; next FLUSH, cnt=FLUSH_CYC-1.
//   * ex_mc_start: if_stall=1, id_dis=0 (ID holds); next MCWAIT, cnt=MC_LAT-2.
//   * load-use: id_valid&id_rf_r&ex_load&(ex_rd==id_ra|ex_rd==id_rb)&ex_rd!=0 -> if_stall=1,
//     ex_bubble=1 for exactly one cycle; no state change.
// - MCWAIT: if_stall=1; cnt decrements; at cnt==0 next RUN. Total stall = MC_LAT-1 cycles.
//   br_taken/exceptions ignored (cannot occur while EX busy).
// - FLUSH: id_dis=1, ex_bubble=1, pc_sel=0; cnt decrements; cnt==0 -> RUN.
// - EXC (1 cycle): pc_sel=2, id_dis=1, ex_bubble=1; next FLUSH with cnt=FLUSH_CYC-1.
// - FLUSH_CYC==1: FLUSH lasts one cycle (cnt loads 0).
// - exc_cause/exc_pc registered, change only on exception entry.
// - Reset asserted mid-MCWAIT/FLUSH: immediate return to RUN, counters cleared.
// STRUCTURE
// - i2d_defines.v gains: I2D_PCSEL_SEQ/BR/VEC, I2D_EXC_NONE/SWI/ERR, state encodings.
// - Single module; counter shared by MCWAIT and FLUSH (4 bits). No sub-module.
// TESTING
// - ex_load=1,ex_rd=5; ID id_ra=5,id_rf_r=1 -> one cycle if_stall=1,ex_bubble=1; ex_rd=0 -> no stall.
// - ex_mc_start pulse, MC_LAT=4 -> if_stall high 3 cycles, then RUN, id_dis never 1.
// - br_taken pulse -> pc_sel=1 same cycle; id_dis,ex_bubble high 1+FLUSH_CYC cycles total (3).
// - id_swi, id_pc=0x100 -> exc_cause=1, exc_pc=0x100, pc_sel=2 next cycle, then 2 flush cycles.
// - same cycle id_swi=1,id_err=1,br_taken=1 -> EXC taken, cause=1, pc_sel=0 that cycle.
// - rst low during MCWAIT cycle 2 -> all outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/i2d_pipe_ctl_pkg.sv
// i2d pipeline controller: shared state encoding, PC-select and exception codes.
package i2d_pipe_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MCWAIT = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_EXC    = 2'd3
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_VEC = 2'd2;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_SWI  = 2'd1;
  localparam logic [1:0] EXC_ERR  = 2'd2;

  // SWI outranks a decode error when both are flagged on the same instruction.
  function automatic logic [1:0] exc_code(input logic swi);
    return swi ? EXC_SWI : EXC_ERR;
  endfunction

endpackage

// File: rtl/i2d_pipe_ctl_if.sv
// i2d pipeline controller bus: decode/execute status in, stage controls out.
interface i2d_pipe_ctl_if #(parameter int RF_AW = 6) ();
  logic             id_valid;
  logic [RF_AW-1:0] id_ra;
  logic [RF_AW-1:0] id_rb;
  logic             id_rf_r;
  logic             id_swi;
  logic             id_err;
  logic [31:0]      id_pc;
  logic             ex_load;
  logic [RF_AW-1:0] ex_rd;
  logic             ex_mc_start;
  logic             br_taken;
  logic             if_stall;
  logic             id_dis;
  logic             ex_bubble;
  logic [1:0]       pc_sel;
  logic [1:0]       exc_cause;
  logic [31:0]      exc_pc;

  // Pipeline side: reports stage status, obeys the controls.
  modport master (
    output id_valid, id_ra, id_rb, id_rf_r, id_swi, id_err, id_pc,
    output ex_load, ex_rd, ex_mc_start, br_taken,
    input  if_stall, id_dis, ex_bubble, pc_sel, exc_cause, exc_pc
  );

  // Controller side.
  modport slave (
    input  id_valid, id_ra, id_rb, id_rf_r, id_swi, id_err, id_pc,
    input  ex_load, ex_rd, ex_mc_start, br_taken,
    output if_stall, id_dis, ex_bubble, pc_sel, exc_cause, exc_pc
  );
endinterface

// File: rtl/i2d_pipe_ctl.sv
// i2d pipeline sequencing controller: load-use interlock, multi-cycle hold,
// branch flush and SWI/decode-error exception redirect.
module i2d_pipe_ctl
  import i2d_pipe_ctl_pkg::*;
#(
  parameter int MC_LAT    = 4,
  parameter int FLUSH_CYC = 2,
  parameter int RF_AW     = 6
) (
  input logic           clk,
  input logic           rst,
  i2d_pipe_ctl_if.slave bus
);

  // The mc_start cycle itself stalls, so MCWAIT covers the remaining MC_LAT-2
  // cycles. Both waits exit on cnt==0, so each loads (cycles in state - 1).
  localparam bit              MC_NEEDS_WAIT = (MC_LAT > 2);
  localparam logic [CNT_W-1:0] MC_LOAD = MC_NEEDS_WAIT ? CNT_W'(MC_LAT - 3) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_CYC - 1);

  state_e           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic [1:0]       exc_cause_r;
  logic [31:0]      exc_pc_r;

  logic             exc_s, load_use_s;
  logic             if_stall_s, id_dis_s, ex_bubble_s;
  logic [1:0]       pc_sel_s;

  assign exc_s      = bus.id_valid & (bus.id_swi | bus.id_err);
  assign load_use_s = bus.id_valid & bus.id_rf_r & bus.ex_load &
                      ((bus.ex_rd == bus.id_ra) | (bus.ex_rd == bus.id_rb)) &
                      (bus.ex_rd != {RF_AW{1'b0}});

  // State and shared wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Next state: exception > branch > multi-cycle start while running.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (exc_s) begin
          next_state_s = ST_EXC;
          next_cnt_s   = {CNT_W{1'b0}};
        end else if (bus.br_taken) begin
          next_state_s = ST_FLUSH;
          next_cnt_s   = FL_LOAD;
        end else if (bus.ex_mc_start && MC_NEEDS_WAIT) begin
          next_state_s = ST_MCWAIT;
          next_cnt_s   = MC_LOAD;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_MCWAIT, ST_FLUSH: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_RUN;
        end else begin
          next_cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_EXC: begin
        next_state_s = ST_FLUSH;
        next_cnt_s   = FL_LOAD;
      end
      default: begin
        next_state_s = ST_RUN;
        next_cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Stage controls from state and current hazards.
  always_comb begin
    if_stall_s  = 1'b0;
    id_dis_s    = 1'b0;
    ex_bubble_s = 1'b0;
    pc_sel_s    = PCSEL_SEQ;
    case (state_r)
      ST_RUN: begin
        if (exc_s) begin
          id_dis_s    = 1'b1;
          ex_bubble_s = 1'b1;
        end else if (bus.br_taken) begin
          pc_sel_s    = PCSEL_BR;
          id_dis_s    = 1'b1;
          ex_bubble_s = 1'b1;
        end else if (bus.ex_mc_start) begin
          if_stall_s  = 1'b1;
        end else if (load_use_s) begin
          if_stall_s  = 1'b1;
          ex_bubble_s = 1'b1;
        end else begin
          if_stall_s  = 1'b0;
        end
      end
      ST_MCWAIT: begin
        if_stall_s = 1'b1;
      end
      ST_FLUSH: begin
        id_dis_s    = 1'b1;
        ex_bubble_s = 1'b1;
      end
      ST_EXC: begin
        pc_sel_s    = PCSEL_VEC;
        id_dis_s    = 1'b1;
        ex_bubble_s = 1'b1;
      end
      default: begin
        if_stall_s = 1'b0;
      end
    endcase
  end

  // Exception record: captured only on exception entry, otherwise sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_cause_r <= EXC_NONE;
      exc_pc_r    <= 32'h0000_0000;
    end else if ((state_r == ST_RUN) && exc_s) begin
      exc_cause_r <= exc_code(bus.id_swi);
      exc_pc_r    <= bus.id_pc;
    end
  end

  assign bus.if_stall  = if_stall_s;
  assign bus.id_dis    = id_dis_s;
  assign bus.ex_bubble = ex_bubble_s;
  assign bus.pc_sel    = pc_sel_s;
  assign bus.exc_cause = exc_cause_r;
  assign bus.exc_pc    = exc_pc_r;

endmodule
